// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write/read engine state encodings.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE      = 2'b00,
      W_WAIT_DATA = 2'b01,
      W_WAIT_ADDR = 2'b10,
      W_RESP      = 2'b11
   } write_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } read_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Word-addressed register memory: synchronous clear, byte-enabled write port, combinational read port.
module axi_lite_regfile
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int IDX_W      = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [IDX_W-1:0]        widx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [IDX_W-1:0]        ridx,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Storage array: cleared by reset, byte lanes written where the strobe is set
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem_r[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_r[ridx];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by axi_lite_regfile, with independent write and read engines.
// Define AXI_MEM_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axi_lite_mem_slave
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 16
)
(
   input  logic                    s0_axi_aclk,
   input  logic                    s0_axi_areset,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic                    s0_axi_awvalid,
   output logic                    s0_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                    s0_axi_wvalid,
   output logic                    s0_axi_wready,
   output logic [1:0]              s0_axi_bresp,
   output logic                    s0_axi_bvalid,
   input  logic                    s0_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
   input  logic                    s0_axi_arvalid,
   output logic                    s0_axi_arready,
   output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
   output logic [1:0]              s0_axi_rresp,
   output logic                    s0_axi_rvalid,
   input  logic                    s0_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Write engine
   write_state_t            w_state_r;
   write_state_t            w_state_nxt_s;
   logic                    awready_r;
   logic                    wready_r;
   logic                    bvalid_r;
   logic [1:0]              bresp_r;
   logic [ADDR_WIDTH-1:0]   aw_addr_r;
   logic [DATA_WIDTH-1:0]   w_data_r;
   logic [STRB_W-1:0]       w_strb_r;
   logic                    aw_hs_s;
   logic                    w_hs_s;
   logic                    b_hs_s;
   logic                    wr_fire_s;
   logic [ADDR_WIDTH-1:0]   wr_addr_s;
   logic [DATA_WIDTH-1:0]   wr_data_s;
   logic [STRB_W-1:0]       wr_strb_s;
   logic                    wr_err_s;
   logic                    mem_we_s;

   // Read engine
   read_state_t             r_state_r;
   read_state_t             r_state_nxt_s;
   logic                    arready_r;
   logic                    rvalid_r;
   logic [DATA_WIDTH-1:0]   rdata_r;
   logic [1:0]              rresp_r;
   logic                    ar_hs_s;
   logic                    r_hs_s;
   logic                    rd_err_s;
   logic [DATA_WIDTH-1:0]   mem_rdata_s;

   assign aw_hs_s = s0_axi_awvalid && awready_r;
   assign w_hs_s  = s0_axi_wvalid  && wready_r;
   assign b_hs_s  = bvalid_r       && s0_axi_bready;
   assign ar_hs_s = s0_axi_arvalid && arready_r;
   assign r_hs_s  = rvalid_r       && s0_axi_rready;

`ifdef AXI_MEM_SLAVE_SLVERR_EN
   assign wr_err_s = (wr_addr_s >> OFFS) >= ADDR_WIDTH'(DEPTH);
   assign rd_err_s = (s0_axi_araddr >> OFFS) >= ADDR_WIDTH'(DEPTH);
`else
   // Without error reporting the word index simply wraps modulo DEPTH
   assign wr_err_s = 1'b0;
   assign rd_err_s = 1'b0;
`endif

   assign mem_we_s = wr_fire_s && !wr_err_s;

   // Write next-state: pairs the AW and W beats in whichever order they arrive
   always_comb begin
      w_state_nxt_s = w_state_r;
      wr_fire_s     = 1'b0;
      wr_addr_s     = s0_axi_awaddr;
      wr_data_s     = s0_axi_wdata;
      wr_strb_s     = s0_axi_wstrb;
      case (w_state_r)
         W_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wr_fire_s     = 1'b1;
               w_state_nxt_s = W_RESP;
            end else if (aw_hs_s) begin
               w_state_nxt_s = W_WAIT_DATA;
            end else if (w_hs_s) begin
               w_state_nxt_s = W_WAIT_ADDR;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_WAIT_DATA: begin
            wr_addr_s = aw_addr_r;
            if (w_hs_s) begin
               wr_fire_s     = 1'b1;
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_WAIT_DATA;
            end
         end
         W_WAIT_ADDR: begin
            wr_data_s = w_data_r;
            wr_strb_s = w_strb_r;
            if (aw_hs_s) begin
               wr_fire_s     = 1'b1;
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_WAIT_ADDR;
            end
         end
         W_RESP: begin
            if (b_hs_s) begin
               w_state_nxt_s = W_IDLE;
            end else begin
               w_state_nxt_s = W_RESP;
            end
         end
         default: begin
            w_state_nxt_s = W_IDLE;
         end
      endcase
   end

   // Write state, registered handshake outputs and beat capture
   always_ff @(posedge s0_axi_aclk) begin
      if (s0_axi_areset) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
         aw_addr_r <= '0;
         w_data_r  <= '0;
         w_strb_r  <= '0;
      end else begin
         w_state_r <= w_state_nxt_s;
         awready_r <= (w_state_nxt_s == W_IDLE) || (w_state_nxt_s == W_WAIT_ADDR);
         wready_r  <= (w_state_nxt_s == W_IDLE) || (w_state_nxt_s == W_WAIT_DATA);
         bvalid_r  <= (w_state_nxt_s == W_RESP);
         if (aw_hs_s) begin
            aw_addr_r <= s0_axi_awaddr;
         end
         if (w_hs_s) begin
            w_data_r <= s0_axi_wdata;
            w_strb_r <= s0_axi_wstrb;
         end
         if (wr_fire_s) begin
            bresp_r <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Read next-state: one outstanding read at a time
   always_comb begin
      r_state_nxt_s = r_state_r;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_state_nxt_s = R_DATA;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (r_hs_s) begin
               r_state_nxt_s = R_IDLE;
            end else begin
               r_state_nxt_s = R_DATA;
            end
         end
         default: begin
            r_state_nxt_s = R_IDLE;
         end
      endcase
   end

   // Read state and response capture; memory is sampled before any same-edge write lands
   always_ff @(posedge s0_axi_aclk) begin
      if (s0_axi_areset) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= '0;
         rresp_r   <= RESP_OKAY;
      end else begin
         r_state_r <= r_state_nxt_s;
         arready_r <= (r_state_nxt_s == R_IDLE);
         rvalid_r  <= (r_state_nxt_s == R_DATA);
         if (ar_hs_s) begin
            rdata_r <= rd_err_s ? '0 : mem_rdata_s;
            rresp_r <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   axi_lite_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clk   (s0_axi_aclk),
      .rst   (s0_axi_areset),
      .we    (mem_we_s),
      .widx  (IDX_W'(wr_addr_s >> OFFS)),
      .wdata (wr_data_s),
      .wstrb (wr_strb_s),
      .ridx  (IDX_W'(s0_axi_araddr >> OFFS)),
      .rdata (mem_rdata_s)
   );

   assign s0_axi_awready = awready_r;
   assign s0_axi_wready  = wready_r;
   assign s0_axi_bvalid  = bvalid_r;
   assign s0_axi_bresp   = bresp_r;
   assign s0_axi_arready = arready_r;
   assign s0_axi_rvalid  = rvalid_r;
   assign s0_axi_rdata   = rdata_r;
   assign s0_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized bench for axi_lite_mem_slave against a word-array reference model.
module tb_axi_lite_mem_slave;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 16;
`ifdef AXI_MEM_SLAVE_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          areset;
   logic [AW-1:0] awaddr;
   logic          awvalid, awready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          wvalid, wready;
   logic [1:0]    bresp;
   logic          bvalid, bready;
   logic [AW-1:0] araddr;
   logic          arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid, rready;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] model [DEPTH];

   always #5 clk = ~clk;

   axi_lite_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .s0_axi_aclk    (clk),
      .s0_axi_areset  (areset),
      .s0_axi_awaddr  (awaddr),
      .s0_axi_awvalid (awvalid),
      .s0_axi_awready (awready),
      .s0_axi_wdata   (wdata),
      .s0_axi_wstrb   (wstrb),
      .s0_axi_wvalid  (wvalid),
      .s0_axi_wready  (wready),
      .s0_axi_bresp   (bresp),
      .s0_axi_bvalid  (bvalid),
      .s0_axi_bready  (bready),
      .s0_axi_araddr  (araddr),
      .s0_axi_arvalid (arvalid),
      .s0_axi_arready (arready),
      .s0_axi_rdata   (rdata),
      .s0_axi_rresp   (rresp),
      .s0_axi_rvalid  (rvalid),
      .s0_axi_rready  (rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: word index is byte address / 4; out of range errors or wraps
   function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input logic [3:0] s);
      int full = int'(a) / 4;
      if (SLVERR_EN && full >= DEPTH) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (s[b]) model[full % DEPTH][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
      int full = int'(a) / 4;
      if (SLVERR_EN && full >= DEPTH) begin
         d = '0;
         r = 2'b10;
      end else begin
         d = model[full % DEPTH];
         r = 2'b00;
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold);
      logic aw_p = 1'b1, w_p = 1'b1, aw_f, w_f;
      logic [1:0] eresp;
      int cyc = 0;
      while ((aw_p || w_p) && cyc < 40) begin
         @(negedge clk);
         if (cyc > 0) check("b_early", bvalid, 1'b0);
         if (cyc > 0 && !w_p && aw_p) check("wait_addr_rdy", {awready, wready}, 2'b10);
         if (cyc > 0 && w_p && !aw_p) check("wait_data_rdy", {awready, wready}, 2'b01);
         awaddr  = a;
         wdata   = d;
         wstrb   = s;
         awvalid = aw_p && (cyc >= aw_dly);
         wvalid  = w_p && (cyc >= w_dly);
         aw_f    = awvalid && awready;
         w_f     = wvalid && wready;
         @(posedge clk);
         if (aw_f) aw_p = 1'b0;
         if (w_f)  w_p  = 1'b0;
         cyc++;
      end
      check("aw_w_accepted", {aw_p, w_p}, 2'b00);
      eresp = model_write(a, d, s);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("bvalid", bvalid, 1'b1);
      check("bresp", bresp, eresp);
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         check("b_hold_valid", bvalid, 1'b1);
         check("b_hold_resp", bresp, eresp);
         check("b_hold_rdy", {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("b_done", bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input int dly, input int hold);
      logic p = 1'b1, f;
      logic [DW-1:0] ed;
      logic [1:0] er;
      int cyc = 0;
      while (p && cyc < 40) begin
         @(negedge clk);
         if (cyc > 0) check("r_early", rvalid, 1'b0);
         araddr  = a;
         arvalid = (cyc >= dly);
         f       = arvalid && arready;
         @(posedge clk);
         if (f) p = 1'b0;
         cyc++;
      end
      check("ar_accepted", p, 1'b0);
      model_read(a, ed, er);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid", rvalid, 1'b1);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         check("r_hold_valid", rvalid, 1'b1);
         check("r_hold_data", rdata, ed);
         check("r_hold_rdy", arready, 1'b0);
      end
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("r_done", rvalid, 1'b0);
   endtask

   // AW, W and AR all on one edge to the same word; read must see the old contents
   task automatic same_edge(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit release_resp);
      logic [DW-1:0] ed;
      logic [1:0] er, eb;
      @(negedge clk);
      check("idle_rdy", {awready, wready, arready}, 3'b111);
      awaddr = a; araddr = a; wdata = d; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      model_read(a, ed, er);
      eb = model_write(a, d, 4'hF);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("se_valids", {bvalid, rvalid}, 2'b11);
      check("se_rdata_old", rdata, ed);
      check("se_rresp", rresp, er);
      check("se_bresp", bresp, eb);
      if (release_resp) begin
         bready = 1'b1; rready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bready = 1'b0; rready = 1'b0;
         check("se_done", {bvalid, rvalid}, 2'b00);
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      areset = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", {awready, wready, arready}, 3'b000);
      check("rst_valid", {bvalid, rvalid}, 2'b00);
      check("rst_rdata", rdata, 32'h0);
      check("rst_resp", {bresp, rresp}, 4'h0);
      areset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_rdy", {awready, wready, arready}, 3'b111);

      axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axi_read(8'h04, 0, 0);
      axi_write(8'h08, 32'h11223344, 4'hF, 2, 0, 0);
      axi_read(8'h08, 0, 0);
      axi_write(8'h0C, 32'hAABBCCDD, 4'h5, 0, 0, 0);
      axi_read(8'h0C, 0, 0);
      axi_write(8'h10, 32'h5A5A0F0F, 4'hF, 0, 0, 5);
      axi_read(8'h10, 0, 5);
      axi_write(8'h40, 32'h00000001, 4'hF, 0, 0, 0);
      axi_read(8'h00, 0, 0);
      axi_write(8'h17, 32'hCAFEF00D, 4'hF, 0, 2, 0);
      axi_read(8'h14, 1, 0);
      axi_write(8'h18, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      axi_read(8'h1A, 0, 0);
      axi_read(8'hFC, 0, 0);
      same_edge(8'h04, 32'h12345678, 1'b1);
      axi_read(8'h04, 0, 0);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 255));
         else a = {2'b00, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         case ($urandom_range(0, 2))
            0: axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 2), $urandom_range(0, 2));
            1: axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
            default: same_edge(a, $urandom, 1'b1);
         endcase
      end

      same_edge(8'h20, 32'h0BADCAFE, 1'b0);
      @(negedge clk);
      areset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_drop_valid", {bvalid, rvalid}, 2'b00);
      check("rst_drop_rdy", {awready, wready, arready}, 3'b000);
      check("rst_drop_rdata", rdata, 32'h0);
      areset = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(posedge clk);
      @(negedge clk);
      check("rerst_rdy", {awready, wready, arready}, 3'b111);
      for (int i = 0; i < DEPTH; i++) axi_read(AW'(i * 4), 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
